syn_gpu_job_dispatcher: RTL and testbench
=========================================

// Module: syn_gpu_job_dispatcher
// PURPOSE
//  Master side of the GPU core job interface. Queues draw jobs from the GPU control path in a FIFO and issues them
//  one at a time to the euclid (line draw) engine: start pulse, job data held, wait for done. A watchdog aborts
//  hung jobs. Sits between the GPU register/command decoder (upstream) and the euclid engine (downstream).
// PARAMETERS
//  JOB_W        64    width of packed gpu_draw_job_t; job data is carried opaque
//  FIFO_DEPTH   8     job queue depth; power of 2, >=2
//  TIMEOUT_W    16    watchdog counter width; timeout = 2**TIMEOUT_W-1 cycles in WAIT_DONE
// PORTS
//  clk_ir            in   1            system clock
//  rst_ih            in   1            async active-high reset
//  job_valid_i       in   1            upstream job push request
//  job_data_i        in   JOB_W        upstream job (gpu_draw_job_t, packed)
//  job_ready_o       out  1            1 -> push accepted this cycle (= queue not full)
//  euclid_job_start  out  1            1-cycle pulse: start job in euclid engine
//  euclid_job_data   out  JOB_W        job being executed; stable from start until done/abort
//  euclid_busy       in   1            1 -> euclid engine busy
//  euclid_job_done   in   1            1-cycle pulse: job complete
//  jobs_pending_o    out  log2(D)+1    jobs in queue (excludes job in flight)
//  dispatch_busy_o   out  1            1 -> job in flight (state != IDLE)
//  jobs_done_cnt_o   out  16           completed jobs, wraps 0xFFFF->0
//  timeout_err_o     out  1            sticky: watchdog fired; cleared only by reset
// BEHAVIOUR
//  Interface: single clock, clk_ir; rst_ih asynchronous, active-high. All outputs registered except job_ready_o.
//  Reset: all outputs 0, queue emptied, FSM IDLE, watchdog 0. Reset mid-job abandons it; no done expected.
//  Queue: push when job_valid_i & job_ready_o; job_ready_o = !full (does NOT look at same-cycle pop).
//   Push+pop same cycle: count unchanged. Push when full: not accepted, data dropped, no state change.
//   Pointers wrap modulo FIFO_DEPTH; full/empty from count.
//  FSM states: IDLE, ISSUE, WAIT_DONE.
//   IDLE: if queue non-empty & euclid_busy==0 -> pop head into euclid_job_data, go ISSUE.
//   ISSUE: euclid_job_start=1 for exactly this cycle; clear watchdog; -> WAIT_DONE.
//   WAIT_DONE: watchdog increments each cycle. euclid_job_done=1 -> jobs_done_cnt_o+1, -> IDLE.
//    Watchdog hits all-ones without done -> timeout_err_o=1, -> IDLE (job dropped, not counted).
//    done and timeout same cycle: done wins, no error.
//  Latency: job pushed into empty queue with engine idle -> start asserted 2 cycles after push cycle
//   (cycle1 visible in queue/IDLE pop, cycle2 ISSUE). Back-to-back: next start >=1 cycle after done (IDLE).
//  euclid_job_done outside WAIT_DONE: ignored, no count. euclid_busy only gates IDLE->ISSUE.
//  euclid_job_data: updated only on pop; holds last job after completion.
//  dispatch_busy_o = (state != IDLE), registered with state.
// TESTING
//  1 Reset: assert rst_ih mid-WAIT_DONE -> all outputs 0 asynchronously, jobs_pending_o=0, no start after release.
//  2 Single job: push 0x..A5 into empty queue, busy=0 -> start pulse 2 cycles later, data=0x..A5; done 10 cyc
//    later -> jobs_done_cnt_o=1, dispatch_busy_o=0 next cycle.
//  3 Fill: push 9 jobs with engine stalled (busy=1) -> 8 accepted, job_ready_o=0 at 8, 9th dropped;
//    release busy, ack each -> 8 starts in push order, pending 8->0.
//  4 Push+pop same cycle at count=3 -> count stays 3; push at full during pop -> rejected (ready=0).
//  5 Watchdog (TIMEOUT_W=4): no done -> after 15 cycles in WAIT_DONE timeout_err_o=1, IDLE, count unchanged;
//    done on 15th cycle -> no error, count+1.
//  6 Spurious done in IDLE -> jobs_done_cnt_o unchanged; counter wrap 0xFFFF + done -> 0.

Source files
------------

// File: rtl/syn_gpu_job_dispatcher_if.sv
// Job interface between the dispatcher, the upstream command decoder and the
// euclid line-draw engine. The master modport is the dispatcher's view.
interface syn_gpu_job_dispatcher_if #(
  parameter int JOB_W = 64
);
  logic             job_valid_i;
  logic [JOB_W-1:0] job_data_i;
  logic             job_ready_o;
  logic             euclid_job_start;
  logic [JOB_W-1:0] euclid_job_data;
  logic             euclid_busy;
  logic             euclid_job_done;

  modport master (
    input  job_valid_i, job_data_i, euclid_busy, euclid_job_done,
    output job_ready_o, euclid_job_start, euclid_job_data
  );

  modport slave (
    output job_valid_i, job_data_i, euclid_busy, euclid_job_done,
    input  job_ready_o, euclid_job_start, euclid_job_data
  );
endinterface

// File: rtl/syn_gpu_job_dispatcher.sv
// GPU job dispatcher: queues opaque draw jobs in a FIFO and hands them one at
// a time to the euclid engine (start pulse, data held, wait for done), with a
// watchdog that drops jobs whose done never arrives.
module syn_gpu_job_dispatcher #(
  parameter int JOB_W      = 64,
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT_W  = 16
) (
  input  logic                        clk_ir,
  input  logic                        rst_ih,
  syn_gpu_job_dispatcher_if.master    jif,
  output logic [$clog2(FIFO_DEPTH):0] jobs_pending_o,
  output logic                        dispatch_busy_o,
  output logic [15:0]                 jobs_done_cnt_o,
  output logic                        timeout_err_o
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  // Last watchdog value before it would reach all-ones: the cycle that
  // completes 2**TIMEOUT_W-1 cycles in WAIT_DONE.
  localparam logic [TIMEOUT_W-1:0] WD_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;

  state_t               state_q, state_n;
  logic [JOB_W-1:0]     mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [TIMEOUT_W-1:0] wd_q;
  logic [JOB_W-1:0]     job_q;
  logic                 start_q, busy_q, err_q;
  logic [15:0]          done_cnt_q;
  logic                 full, empty, push, pop, done_evt, tmo_evt;

  // Ready only looks at fullness, never at a same-cycle pop.
  assign full  = (cnt_q == DEPTH_C);
  assign empty = (cnt_q == '0);
  assign push  = jif.job_valid_i & ~full;

  assign jif.job_ready_o      = ~full;
  assign jif.euclid_job_start = start_q;
  assign jif.euclid_job_data  = job_q;
  assign jobs_pending_o       = cnt_q;
  assign dispatch_busy_o      = busy_q;
  assign jobs_done_cnt_o      = done_cnt_q;
  assign timeout_err_o        = err_q;

  // Next-state and per-cycle events; done takes priority over the watchdog.
  always_comb begin
    state_n  = state_q;
    pop      = 1'b0;
    done_evt = 1'b0;
    tmo_evt  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty && !jif.euclid_busy) begin
          pop     = 1'b1;
          state_n = ISSUE;
        end
      end
      ISSUE: state_n = WAIT_DONE;
      WAIT_DONE: begin
        if (jif.euclid_job_done) begin
          done_evt = 1'b1;
          state_n  = IDLE;
        end else if (wd_q == WD_LAST) begin
          tmo_evt = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_ir or posedge rst_ih) begin
    if (rst_ih) state_q <= IDLE;
    else        state_q <= state_n;
  end

  // Queue pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge clk_ir or posedge rst_ih) begin
    if (rst_ih) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: ;
      endcase
    end
  end

  // Queue storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk_ir) begin
    if (push) mem[wr_ptr_q] <= jif.job_data_i;
  end

  // Registered engine-side outputs, watchdog and status.
  always_ff @(posedge clk_ir or posedge rst_ih) begin
    if (rst_ih) begin
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
      job_q      <= '0;
      wd_q       <= '0;
      err_q      <= 1'b0;
      done_cnt_q <= '0;
    end else begin
      start_q <= pop;
      busy_q  <= (state_n != IDLE);
      if (pop) job_q <= mem[rd_ptr_q];
      if (state_q == ISSUE)          wd_q <= '0;
      else if (state_q == WAIT_DONE) wd_q <= wd_q + 1'b1;
      if (tmo_evt)  err_q      <= 1'b1;
      if (done_evt) done_cnt_q <= done_cnt_q + 16'd1;
    end
  end
endmodule

// File: tb/tb_syn_gpu_job_dispatcher.sv
// Directed bench for syn_gpu_job_dispatcher (FIFO_DEPTH=8, TIMEOUT_W=4).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_syn_gpu_job_dispatcher;
  localparam int JOB_W = 64;

  logic        clk_ir = 1'b0;
  logic        rst_ih = 1'b1;
  logic [3:0]  jobs_pending_o;
  logic        dispatch_busy_o;
  logic [15:0] jobs_done_cnt_o;
  logic        timeout_err_o;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_done = '0;

  syn_gpu_job_dispatcher_if #(.JOB_W(JOB_W)) jif ();

  syn_gpu_job_dispatcher #(.JOB_W(JOB_W), .FIFO_DEPTH(8), .TIMEOUT_W(4)) dut (
    .clk_ir          (clk_ir),
    .rst_ih          (rst_ih),
    .jif             (jif),
    .jobs_pending_o  (jobs_pending_o),
    .dispatch_busy_o (dispatch_busy_o),
    .jobs_done_cnt_o (jobs_done_cnt_o),
    .timeout_err_o   (timeout_err_o)
  );

  always #5 clk_ir = ~clk_ir;

  task automatic tick();
    @(negedge clk_ir);
  endtask

  task automatic push_one(input logic [63:0] d);
    jif.job_valid_i = 1'b1;
    jif.job_data_i  = d;
    tick();
    jif.job_valid_i = 1'b0;
  endtask

  // Waits (bounded) for a start, captures what was seen, then acks with done.
  task automatic serve_job(output logic [63:0] got, output logic [3:0] pend, output bit seen);
    int w = 0;
    while (!jif.euclid_job_start && w < 20) begin tick(); w++; end
    seen = jif.euclid_job_start;
    got  = jif.euclid_job_data;
    pend = jobs_pending_o;
    tick();
    jif.euclid_job_done = 1'b1;
    tick();
    jif.euclid_job_done = 1'b0;
  endtask

  task automatic test_reset();
    jif.job_valid_i = 0; jif.job_data_i = '0; jif.euclid_busy = 0; jif.euclid_job_done = 0;
    rst_ih = 1'b1;
    tick(); tick();
    n_checks++; if (jif.euclid_job_start !== 1'b0) begin n_fail++; $display("FAIL rst_start got=%0h exp=0", jif.euclid_job_start); end
    n_checks++; if (jif.euclid_job_data !== 64'h0) begin n_fail++; $display("FAIL rst_data got=%0h exp=0", jif.euclid_job_data); end
    n_checks++; if (jobs_pending_o !== 4'd0) begin n_fail++; $display("FAIL rst_pending got=%0d exp=0", jobs_pending_o); end
    n_checks++; if (dispatch_busy_o !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%0h exp=0", dispatch_busy_o); end
    n_checks++; if (jobs_done_cnt_o !== 16'd0) begin n_fail++; $display("FAIL rst_cnt got=%0h exp=0", jobs_done_cnt_o); end
    n_checks++; if (timeout_err_o !== 1'b0) begin n_fail++; $display("FAIL rst_err got=%0h exp=0", timeout_err_o); end
    n_checks++; if (jif.job_ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_ready got=%0h exp=1", jif.job_ready_o); end
    rst_ih = 1'b0;
    tick();
  endtask

  task automatic test_single();
    logic [63:0] d = 64'h0123_4567_89AB_CDA5;
    push_one(d);
    n_checks++; if (jif.euclid_job_start !== 1'b0) begin n_fail++; $display("FAIL single_nostart1 got=%0h exp=0", jif.euclid_job_start); end
    n_checks++; if (jobs_pending_o !== 4'd1) begin n_fail++; $display("FAIL single_pend1 got=%0d exp=1", jobs_pending_o); end
    tick();
    n_checks++; if (jif.euclid_job_start !== 1'b1) begin n_fail++; $display("FAIL single_start got=%0h exp=1", jif.euclid_job_start); end
    n_checks++; if (jif.euclid_job_data !== d) begin n_fail++; $display("FAIL single_data got=%0h exp=%0h", jif.euclid_job_data, d); end
    n_checks++; if (dispatch_busy_o !== 1'b1) begin n_fail++; $display("FAIL single_busy got=%0h exp=1", dispatch_busy_o); end
    n_checks++; if (jobs_pending_o !== 4'd0) begin n_fail++; $display("FAIL single_pend0 got=%0d exp=0", jobs_pending_o); end
    tick();
    n_checks++; if (jif.euclid_job_start !== 1'b0) begin n_fail++; $display("FAIL single_pulse got=%0h exp=0", jif.euclid_job_start); end
    repeat (8) tick();
    jif.euclid_job_done = 1'b1;
    tick();
    jif.euclid_job_done = 1'b0;
    exp_done++;
    n_checks++; if (jobs_done_cnt_o !== exp_done) begin n_fail++; $display("FAIL single_cnt got=%0d exp=%0d", jobs_done_cnt_o, exp_done); end
    n_checks++; if (dispatch_busy_o !== 1'b0) begin n_fail++; $display("FAIL single_idle got=%0h exp=0", dispatch_busy_o); end
    n_checks++; if (jif.euclid_job_data !== d) begin n_fail++; $display("FAIL single_hold got=%0h exp=%0h", jif.euclid_job_data, d); end
  endtask

  task automatic test_fill();
    logic [63:0] jobs [9];
    logic [63:0] got;
    logic [3:0]  pend;
    bit          seen;
    logic        exp_r;
    for (int i = 0; i < 9; i++) jobs[i] = 64'hF000_0000_0000_0000 | 64'(i * 16 + 3);
    jif.euclid_busy = 1'b1;
    for (int i = 0; i < 9; i++) begin
      exp_r = (i < 8);
      n_checks++; if (jif.job_ready_o !== exp_r) begin n_fail++; $display("FAIL fill_ready[%0d] got=%0h exp=%0h", i, jif.job_ready_o, exp_r); end
      jif.job_valid_i = 1'b1;
      jif.job_data_i  = jobs[i];
      tick();
    end
    jif.job_valid_i = 1'b0;
    n_checks++; if (jobs_pending_o !== 4'd8) begin n_fail++; $display("FAIL fill_pend got=%0d exp=8", jobs_pending_o); end
    n_checks++; if (jif.euclid_job_start !== 1'b0) begin n_fail++; $display("FAIL fill_stalled got=%0h exp=0", jif.euclid_job_start); end
    jif.euclid_busy = 1'b0;
    for (int k = 0; k < 8; k++) begin
      serve_job(got, pend, seen);
      n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL fill_seen[%0d] got=%0h exp=1", k, seen); end
      n_checks++; if (got !== jobs[k]) begin n_fail++; $display("FAIL fill_order[%0d] got=%0h exp=%0h", k, got, jobs[k]); end
      n_checks++; if (pend !== 4'(7 - k)) begin n_fail++; $display("FAIL fill_pend[%0d] got=%0d exp=%0d", k, pend, 7 - k); end
    end
    exp_done += 16'd8;
    n_checks++; if (jobs_done_cnt_o !== exp_done) begin n_fail++; $display("FAIL fill_cnt got=%0d exp=%0d", jobs_done_cnt_o, exp_done); end
    n_checks++; if (jobs_pending_o !== 4'd0) begin n_fail++; $display("FAIL fill_empty got=%0d exp=0", jobs_pending_o); end
  endtask

  task automatic test_push_pop();
    logic [63:0] exp_q [8];
    logic [63:0] got;
    logic [3:0]  pend;
    bit          seen;
    logic [63:0] dropped = 64'hDEAD_0000_0000_0099;
    for (int i = 0; i < 8; i++) exp_q[i] = 64'hB000_0000_0000_0000 | 64'(i + 1);
    jif.euclid_busy = 1'b1;
    push_one(64'hB000_0000_0000_0000);
    push_one(exp_q[0]);
    push_one(exp_q[1]);
    n_checks++; if (jobs_pending_o !== 4'd3) begin n_fail++; $display("FAIL pp_pend3 got=%0d exp=3", jobs_pending_o); end
    jif.euclid_busy = 1'b0;
    push_one(exp_q[2]);
    n_checks++; if (jobs_pending_o !== 4'd3) begin n_fail++; $display("FAIL pp_samecyc got=%0d exp=3", jobs_pending_o); end
    n_checks++; if (jif.euclid_job_start !== 1'b1) begin n_fail++; $display("FAIL pp_start got=%0h exp=1", jif.euclid_job_start); end
    n_checks++; if (jif.euclid_job_data !== 64'hB000_0000_0000_0000) begin n_fail++; $display("FAIL pp_data got=%0h exp=b000000000000000", jif.euclid_job_data); end
    jif.euclid_busy = 1'b1;
    tick();
    jif.euclid_job_done = 1'b1;
    tick();
    jif.euclid_job_done = 1'b0;
    exp_done++;
    for (int i = 3; i < 8; i++) push_one(exp_q[i]);
    n_checks++; if (jobs_pending_o !== 4'd8) begin n_fail++; $display("FAIL pp_full got=%0d exp=8", jobs_pending_o); end
    jif.euclid_busy = 1'b0;
    n_checks++; if (jif.job_ready_o !== 1'b0) begin n_fail++; $display("FAIL pp_ready_full got=%0h exp=0", jif.job_ready_o); end
    push_one(dropped);
    n_checks++; if (jobs_pending_o !== 4'd7) begin n_fail++; $display("FAIL pp_reject got=%0d exp=7", jobs_pending_o); end
    n_checks++; if (jif.job_ready_o !== 1'b1) begin n_fail++; $display("FAIL pp_ready_after got=%0h exp=1", jif.job_ready_o); end
    for (int k = 0; k < 8; k++) begin
      serve_job(got, pend, seen);
      n_checks++; if (seen !== 1'b1 || got !== exp_q[k]) begin n_fail++; $display("FAIL pp_order[%0d] got=%0h seen=%0h exp=%0h", k, got, seen, exp_q[k]); end
    end
    exp_done += 16'd8;
    n_checks++; if (jobs_pending_o !== 4'd0) begin n_fail++; $display("FAIL pp_empty got=%0d exp=0", jobs_pending_o); end
    n_checks++; if (jobs_done_cnt_o !== exp_done) begin n_fail++; $display("FAIL pp_cnt got=%0d exp=%0d", jobs_done_cnt_o, exp_done); end
  endtask

  task automatic test_watchdog();
    int w;
    push_one(64'h0000_0000_0000_0D15);
    w = 0;
    while (!jif.euclid_job_start && w < 20) begin tick(); w++; end
    n_checks++; if (jif.euclid_job_start !== 1'b1) begin n_fail++; $display("FAIL wd_start1 got=%0h exp=1", jif.euclid_job_start); end
    repeat (15) tick();
    jif.euclid_job_done = 1'b1;
    tick();
    jif.euclid_job_done = 1'b0;
    exp_done++;
    n_checks++; if (timeout_err_o !== 1'b0) begin n_fail++; $display("FAIL wd_done_wins got=%0h exp=0", timeout_err_o); end
    n_checks++; if (jobs_done_cnt_o !== exp_done) begin n_fail++; $display("FAIL wd_done_cnt got=%0d exp=%0d", jobs_done_cnt_o, exp_done); end
    n_checks++; if (dispatch_busy_o !== 1'b0) begin n_fail++; $display("FAIL wd_done_idle got=%0h exp=0", dispatch_busy_o); end
    push_one(64'h0000_0000_0000_0D16);
    w = 0;
    while (!jif.euclid_job_start && w < 20) begin tick(); w++; end
    n_checks++; if (jif.euclid_job_start !== 1'b1) begin n_fail++; $display("FAIL wd_start2 got=%0h exp=1", jif.euclid_job_start); end
    repeat (15) tick();
    n_checks++; if (timeout_err_o !== 1'b0 || dispatch_busy_o !== 1'b1) begin n_fail++; $display("FAIL wd_early err=%0h busy=%0h exp err=0 busy=1", timeout_err_o, dispatch_busy_o); end
    tick();
    n_checks++; if (timeout_err_o !== 1'b1) begin n_fail++; $display("FAIL wd_fire got=%0h exp=1", timeout_err_o); end
    n_checks++; if (dispatch_busy_o !== 1'b0) begin n_fail++; $display("FAIL wd_idle got=%0h exp=0", dispatch_busy_o); end
    n_checks++; if (jobs_done_cnt_o !== exp_done) begin n_fail++; $display("FAIL wd_cnt got=%0d exp=%0d", jobs_done_cnt_o, exp_done); end
  endtask

  task automatic test_spurious_wrap();
    logic [63:0] got;
    logic [3:0]  pend;
    bit          seen;
    jif.euclid_job_done = 1'b1;
    tick();
    jif.euclid_job_done = 1'b0;
    tick();
    n_checks++; if (jobs_done_cnt_o !== exp_done) begin n_fail++; $display("FAIL spur_cnt got=%0d exp=%0d", jobs_done_cnt_o, exp_done); end
    force dut.done_cnt_q = 16'hFFFF;
    tick();
    release dut.done_cnt_q;
    tick();
    n_checks++; if (jobs_done_cnt_o !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_preset got=%0h exp=ffff", jobs_done_cnt_o); end
    push_one(64'h0000_0000_0000_FFFF);
    serve_job(got, pend, seen);
    exp_done = 16'h0000;
    n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL wrap_seen got=%0h exp=1", seen); end
    n_checks++; if (jobs_done_cnt_o !== exp_done) begin n_fail++; $display("FAIL wrap_cnt got=%0h exp=0", jobs_done_cnt_o); end
  endtask

  task automatic test_reset_mid();
    logic [63:0] got;
    logic [3:0]  pend;
    bit          seen;
    push_one(64'h0000_0000_0000_0A01);
    serve_job(got, pend, seen);
    jif.job_valid_i = 1'b1;
    jif.job_data_i  = 64'h0000_0000_0000_0A02;
    tick();
    jif.job_data_i  = 64'h0000_0000_0000_0A03;
    tick();
    jif.job_valid_i = 1'b0;
    tick(); tick();
    n_checks++; if (dispatch_busy_o !== 1'b1 || jobs_pending_o !== 4'd1) begin n_fail++; $display("FAIL rmid_pre busy=%0h pend=%0d exp busy=1 pend=1", dispatch_busy_o, jobs_pending_o); end
    #2 rst_ih = 1'b1;
    #1;
    n_checks++; if (jif.euclid_job_start !== 1'b0) begin n_fail++; $display("FAIL rmid_start got=%0h exp=0", jif.euclid_job_start); end
    n_checks++; if (jif.euclid_job_data !== 64'h0) begin n_fail++; $display("FAIL rmid_data got=%0h exp=0", jif.euclid_job_data); end
    n_checks++; if (jobs_pending_o !== 4'd0) begin n_fail++; $display("FAIL rmid_pend got=%0d exp=0", jobs_pending_o); end
    n_checks++; if (dispatch_busy_o !== 1'b0) begin n_fail++; $display("FAIL rmid_busy got=%0h exp=0", dispatch_busy_o); end
    n_checks++; if (jobs_done_cnt_o !== 16'd0) begin n_fail++; $display("FAIL rmid_cnt got=%0h exp=0", jobs_done_cnt_o); end
    n_checks++; if (timeout_err_o !== 1'b0) begin n_fail++; $display("FAIL rmid_err got=%0h exp=0", timeout_err_o); end
    tick();
    rst_ih = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      tick();
      if (jif.euclid_job_start === 1'b1) seen = 1'b1;
    end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rmid_nostart got=%0h exp=0", seen); end
    n_checks++; if (jobs_pending_o !== 4'd0) begin n_fail++; $display("FAIL rmid_pend_after got=%0d exp=0", jobs_pending_o); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_push_pop();
    test_watchdog();
    test_spurious_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation time limit reached");
  end
endmodule
